// File: rtl/bip_pkg.sv
`default_nettype none
// ============================================================================
// Module      : bip_pkg
// Description : Shared definitions for the BIP control unit. Holds the opcode
//               values, the accumulator-source and ALU select encodings, the
//               control-unit state encoding and the decoded control bundle.
// Revision    : 1.0 - initial release
// ============================================================================
package bip_pkg;

    // Opcode field width of an instruction word.
    localparam int OPC_WIDTH = 5;

    // Opcodes. Every value not listed here executes as a NOP.
    localparam logic [OPC_WIDTH-1:0] OPC_HLT  = 5'b00000;
    localparam logic [OPC_WIDTH-1:0] OPC_STO  = 5'b00001;
    localparam logic [OPC_WIDTH-1:0] OPC_LD   = 5'b00010;
    localparam logic [OPC_WIDTH-1:0] OPC_LDI  = 5'b00011;
    localparam logic [OPC_WIDTH-1:0] OPC_ADD  = 5'b00100;
    localparam logic [OPC_WIDTH-1:0] OPC_ADDI = 5'b00101;
    localparam logic [OPC_WIDTH-1:0] OPC_SUB  = 5'b00110;
    localparam logic [OPC_WIDTH-1:0] OPC_SUBI = 5'b00111;

    // Accumulator source select. 2'b11 is never produced.
    typedef enum logic [1:0] {
        SELA_MEMORY = 2'b00,
        SELA_SIGNAL = 2'b01,
        SELA_ALU    = 2'b10
    } sela_e;

    // ALU B-operand select.
    localparam logic SELB_MEMORY = 1'b0;
    localparam logic SELB_IMM    = 1'b1;

    // ALU operation.
    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    // Control-unit states.
    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_HALT = 2'b10
    } state_e;

    // Decoded control bundle for one instruction.
    typedef struct packed {
        sela_e sel_a;
        logic  sel_b;
        logic  op;
        logic  wr_acc;
        logic  wr_ram;
        logic  rd_ram;
    } ctrl_t;

endpackage : bip_pkg
`default_nettype wire

// File: rtl/bip_control_if.sv
`default_nettype none
// ============================================================================
// Module      : bip_control_if
// Description : Datapath-control bundle driven by the BIP control unit and
//               consumed by the accumulator input mux, ALU and data RAM.
//   operand : instruction operand field (RAM address / immediate source)
//   SelA    : accumulator source (00 memory, 01 immediate, 10 ALU)
//   SelB    : ALU B operand (0 memory, 1 immediate)
//   Op      : ALU operation (0 add, 1 subtract)
//   WrAcc   : accumulator write enable
//   WrRam   : data-RAM write strobe
//   RdRam   : data-RAM read strobe
// Revision    : 1.0 - initial release
// ============================================================================
interface bip_control_if #(
    parameter int PC_W = 11
);
    logic [PC_W-1:0] operand;
    logic [1:0]      SelA;
    logic            SelB;
    logic            Op;
    logic            WrAcc;
    logic            WrRam;
    logic            RdRam;

    modport master (
        output operand, SelA, SelB, Op, WrAcc, WrRam, RdRam
    );

    modport slave (
        input  operand, SelA, SelB, Op, WrAcc, WrRam, RdRam
    );
endinterface : bip_control_if
`default_nettype wire

// File: rtl/bip_control_decoder.sv
`default_nettype none
// ============================================================================
// Module      : bip_decoder
// Description : Purely combinational opcode decoder for the BIP processor.
//   opc_i  : instruction opcode field
//   ctrl_o : decoded {SelA, SelB, Op, WrAcc, WrRam, RdRam}
//            HLT and unlisted opcodes decode to all zeros.
// Revision    : 1.0 - initial release
// ============================================================================
module bip_decoder
    import bip_pkg::*;
(
    input  wire logic [OPC_WIDTH-1:0] opc_i,
    output ctrl_t                     ctrl_o
);

    always_comb begin
        ctrl_o = '0;
        case (opc_i)
            OPC_STO: begin
                ctrl_o.wr_ram = 1'b1;
            end
            OPC_LD: begin
                ctrl_o.rd_ram = 1'b1;
                ctrl_o.wr_acc = 1'b1;
                ctrl_o.sel_a  = SELA_MEMORY;
            end
            OPC_LDI: begin
                ctrl_o.wr_acc = 1'b1;
                ctrl_o.sel_a  = SELA_SIGNAL;
            end
            OPC_ADD, OPC_SUB: begin
                ctrl_o.rd_ram = 1'b1;
                ctrl_o.wr_acc = 1'b1;
                ctrl_o.sel_a  = SELA_ALU;
                ctrl_o.sel_b  = SELB_MEMORY;
                ctrl_o.op     = (opc_i == OPC_SUB) ? OP_SUB : OP_ADD;
            end
            OPC_ADDI, OPC_SUBI: begin
                ctrl_o.wr_acc = 1'b1;
                ctrl_o.sel_a  = SELA_ALU;
                ctrl_o.sel_b  = SELB_IMM;
                ctrl_o.op     = (opc_i == OPC_SUBI) ? OP_SUB : OP_ADD;
            end
            default: begin
                // HLT and NOPs drive nothing.
            end
        endcase
    end

endmodule : bip_decoder
`default_nettype wire

// File: rtl/bip_control.sv
`default_nettype none
// ============================================================================
// Module      : bip_control
// Description : BIP accumulator-processor control unit. Holds the program
//               counter and the IDLE/RUN/HALT state machine, fetches the
//               instruction at pc and drives the datapath controls.
//   clk         : system clock, rising edge
//   rst_n       : asynchronous active-low reset
//   start       : run request (IDLE -> RUN, or restart from HALT)
//   instr       : program word at address pc (same-cycle read)
//   pc          : program-memory address
//   halted      : high while in HALT
//   instr_count : executed non-HLT instructions, saturating
//   bus         : datapath-control bundle (master side)
// Revision    : 1.0 - initial release
// ============================================================================
module bip_control
    import bip_pkg::*;
#(
    parameter int PC_W  = 11,
    parameter int OPC_W = OPC_WIDTH,
    parameter int CNT_W = 16
) (
    input  wire logic                  clk,
    input  wire logic                  rst_n,
    input  wire logic                  start,
    input  wire logic [OPC_W+PC_W-1:0] instr,
    output logic      [PC_W-1:0]       pc,
    output logic                       halted,
    output logic      [CNT_W-1:0]      instr_count,
    bip_control_if.master              bus
);

    state_e            state_q;
    logic [PC_W-1:0]   pc_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              halted_q;

    logic [OPC_W-1:0]  w_opcode;
    logic              w_is_hlt;
    ctrl_t             w_dec;
    ctrl_t             w_ctrl;
    logic [PC_W-1:0]   pc_d;
    logic [CNT_W-1:0]  cnt_d;

    assign w_opcode = instr[OPC_W+PC_W-1 -: OPC_W];
    assign w_is_hlt = (w_opcode == OPC_HLT);

    bip_decoder u_decoder (
        .opc_i  (w_opcode),
        .ctrl_o (w_dec)
    );

    // Decode is only visible while running; the state register resets
    // asynchronously, so the controls drop to zero as soon as rst_n falls.
    assign w_ctrl = (state_q == ST_RUN) ? w_dec : ctrl_t'('0);

    // pc wraps naturally; the counter sticks at all-ones.
    assign pc_d  = pc_q + 1'b1;
    assign cnt_d = (&cnt_q) ? cnt_q : cnt_q + 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            pc_q     <= '0;
            cnt_q    <= '0;
            halted_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        state_q <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    // start is deliberately ignored while running.
                    if (w_is_hlt) begin
                        state_q  <= ST_HALT;
                        halted_q <= 1'b1;
                    end else begin
                        pc_q  <= pc_d;
                        cnt_q <= cnt_d;
                    end
                end
                ST_HALT: begin
                    // Restart always begins a fresh run from address 0.
                    if (start) begin
                        state_q  <= ST_RUN;
                        pc_q     <= '0;
                        cnt_q    <= '0;
                        halted_q <= 1'b0;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign pc          = pc_q;
    assign halted      = halted_q;
    assign instr_count = cnt_q;

    assign bus.operand = instr[PC_W-1:0];
    assign bus.SelA    = w_ctrl.sel_a;
    assign bus.SelB    = w_ctrl.sel_b;
    assign bus.Op      = w_ctrl.op;
    assign bus.WrAcc   = w_ctrl.wr_acc;
    assign bus.WrRam   = w_ctrl.wr_ram;
    assign bus.RdRam   = w_ctrl.rd_ram;

endmodule : bip_control
`default_nettype wire

// File: tb/tb_bip_control.sv
`default_nettype none
// ============================================================================
// Module      : tb_bip_control
// Description : Self-checking bench for bip_control. A program memory feeds
//               instr from pc; a behavioural model tracks mode, pc, count and
//               halted, and the expected controls come from the decode table.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bip_control;

    localparam int PC_W  = 11;
    localparam int OPC_W = 5;
    localparam int CNT_W = 16;
    localparam int DEPTH = 1 << PC_W;
    localparam int CMAX  = (1 << CNT_W) - 1;

    localparam int M_IDLE = 0;
    localparam int M_RUN  = 1;
    localparam int M_HALT = 2;

    logic             clk   = 1'b0;
    logic             rst_n = 1'b0;
    logic             start = 1'b0;
    logic [15:0]      instr;
    logic [PC_W-1:0]  pc;
    logic             halted;
    logic [CNT_W-1:0] instr_count;

    logic [15:0] prog [DEPTH];

    int checks = 0;
    int errors = 0;

    int m_mode   = M_IDLE;
    int m_pc     = 0;
    int m_cnt    = 0;
    bit m_halted = 1'b0;

    bip_control_if #(.PC_W(PC_W)) bus ();

    bip_control #(
        .PC_W  (PC_W),
        .OPC_W (OPC_W),
        .CNT_W (CNT_W)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .instr       (instr),
        .pc          (pc),
        .halted      (halted),
        .instr_count (instr_count),
        .bus         (bus)
    );

    always #5 clk = ~clk;

    always_comb instr = prog[pc];

    // {SelA[1:0], SelB, Op, WrAcc, WrRam, RdRam} for each opcode.
    function automatic logic [6:0] ref_ctrl(input int opc);
        case (opc)
            1:       return 7'b00_0_0_0_1_0;  // STO
            2:       return 7'b00_0_0_1_0_1;  // LD
            3:       return 7'b01_0_0_1_0_0;  // LDI
            4:       return 7'b10_0_0_1_0_1;  // ADD
            5:       return 7'b10_1_0_1_0_0;  // ADDI
            6:       return 7'b10_0_1_1_0_1;  // SUB
            7:       return 7'b10_1_1_1_0_0;  // SUBI
            default: return 7'b00_0_0_0_0_0;  // HLT / NOP
        endcase
    endfunction

    function automatic logic [15:0] mk(input int opc, input int opd);
        logic [4:0]  o;
        logic [10:0] d;
        o = opc[4:0];
        d = opd[10:0];
        return {o, d};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One cycle: drive inputs at the falling edge, compare against the model,
    // then advance the model to what the next rising edge must produce.
    task automatic step(input bit st, input bit rn);
        logic [15:0] w;
        int          opc;
        logic [6:0]  exp_ctrl;
        @(negedge clk);
        start = st;
        rst_n = rn;
        #1;
        if (!rn) begin
            m_mode = M_IDLE; m_pc = 0; m_cnt = 0; m_halted = 1'b0;
        end
        w        = prog[m_pc];
        opc      = int'(w[15:11]);
        exp_ctrl = (m_mode == M_RUN) ? ref_ctrl(opc) : 7'd0;
        chk("ctrl", {bus.SelA, bus.SelB, bus.Op, bus.WrAcc, bus.WrRam, bus.RdRam}, exp_ctrl);
        chk("pc", pc, m_pc);
        chk("halted", halted, m_halted);
        chk("count", instr_count, m_cnt);
        chk("operand", bus.operand, w[10:0]);
        chk("sela_legal", bus.SelA != 2'b11, 1);
        if (rn) begin
            case (m_mode)
                M_IDLE: if (st) m_mode = M_RUN;
                M_RUN: begin
                    if (opc == 0) begin
                        m_mode = M_HALT; m_halted = 1'b1;
                    end else begin
                        m_pc = (m_pc + 1) % DEPTH;
                        if (m_cnt < CMAX) m_cnt++;
                    end
                end
                default: if (st) begin
                    m_mode = M_RUN; m_pc = 0; m_cnt = 0; m_halted = 1'b0;
                end
            endcase
        end
    endtask

    initial begin
        int budget;

        for (int i = 0; i < DEPTH; i++) prog[i] = mk(31, $urandom);

        // Reset held for five cycles with start low.
        for (int i = 0; i < 5; i++) step(1'b0, 1'b0);
        step(1'b0, 1'b1);
        chk("rst_pc", pc, 0);
        chk("rst_halted", halted, 0);
        chk("rst_sela", bus.SelA, 2'b00);

        // LDI 5, ADDI 3, STO 2, HLT.
        prog[0] = mk(3, 5);
        prog[1] = mk(5, 3);
        prog[2] = mk(1, 2);
        prog[3] = mk(0, 0);
        step(1'b1, 1'b1);
        step(1'b0, 1'b1);
        chk("p1_sela_ldi", bus.SelA, 2'b01);
        step(1'b0, 1'b1);
        chk("p1_sela_addi", bus.SelA, 2'b10);
        chk("p1_addi_bits", {bus.SelB, bus.Op, bus.WrAcc}, 3'b101);
        step(1'b0, 1'b1);
        chk("p1_sela_sto", bus.SelA, 2'b00);
        chk("p1_sto_wrram", bus.WrRam, 1);
        step(1'b0, 1'b1);
        chk("p1_hlt_halted_late", halted, 0);
        step(1'b0, 1'b1);
        chk("p1_halted", halted, 1);
        chk("p1_pc", pc, 3);
        chk("p1_count", instr_count, 3);

        // Restart: LD 7, SUB 8, ADD, ADDI, opcode 11111, HLT.
        prog[0] = mk(2, 7);
        prog[1] = mk(6, 8);
        prog[2] = mk(4, $urandom);
        prog[3] = mk(5, $urandom);
        prog[4] = mk(31, $urandom);
        prog[5] = mk(0, $urandom);
        step(1'b1, 1'b1);
        step(1'b0, 1'b1);
        chk("p2_restart_pc", pc, 0);
        chk("p2_restart_cnt", instr_count, 0);
        chk("p2_ld", {bus.RdRam, bus.SelA, bus.WrAcc}, 4'b1_00_1);
        step(1'b0, 1'b1);
        chk("p2_sub", {bus.RdRam, bus.SelA, bus.SelB, bus.Op}, 5'b1_10_0_1);
        chk("p2_sub_pc", pc, 1);
        step(1'b0, 1'b1);
        step(1'b0, 1'b1);
        step(1'b0, 1'b1);
        chk("p2_nop_ctrl", {bus.SelA, bus.SelB, bus.Op, bus.WrAcc, bus.WrRam, bus.RdRam}, 0);
        step(1'b0, 1'b1);
        chk("p2_nop_pc", pc, 5);
        chk("p2_nop_cnt", instr_count, 5);
        step(1'b0, 1'b1);

        // Random programs with sparse HLTs and random start pulses.
        for (int i = 0; i < DEPTH; i++)
            prog[i] = ($urandom_range(0, 39) == 0) ? mk(0, $urandom)
                                                   : mk($urandom_range(1, 31), $urandom);
        for (int i = 0; i < 400; i++) step($urandom_range(0, 5) == 0, 1'b1);

        // NOP stream across the pc wrap point.
        for (int i = 0; i < DEPTH; i++) prog[i] = mk($urandom_range(8, 31), $urandom);
        step(1'b0, 1'b0);
        step(1'b1, 1'b1);
        budget = 0;
        while (m_pc != DEPTH - 1 && budget < DEPTH + 16) begin
            step($urandom_range(0, 1) == 1, 1'b1);
            budget++;
        end
        chk("wrap_reached", m_pc, DEPTH - 1);
        step(1'b0, 1'b1);
        step(1'b0, 1'b1);
        chk("wrap_pc", pc, 0);
        chk("wrap_halted", halted, 0);
        step(1'b1, 1'b1);
        step(1'b0, 1'b1);

        // Asynchronous reset mid-run.
        step(1'b0, 1'b0);
        chk("midrst_pc", pc, 0);
        chk("midrst_ctrl", {bus.SelA, bus.WrAcc, bus.WrRam, bus.RdRam}, 0);
        step(1'b0, 1'b0);
        step(1'b0, 1'b1);
        step(1'b0, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_bip_control
`default_nettype wire
